// File: rtl/cache_pkg.sv
// Shared types and defaults for the CPU-side cache controller.
package cache_pkg;

   typedef enum logic [1:0] {
      LS_I = 2'b00,
      LS_S = 2'b01,
      LS_E = 2'b10,
      LS_M = 2'b11
   } line_state_t;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_LOOKUP    = 4'd1,
      ST_WB_REQ    = 4'd2,
      ST_WB_WAIT   = 4'd3,
      ST_FILL_REQ  = 4'd4,
      ST_FILL_WAIT = 4'd5,
      ST_FILL_UPD  = 4'd6,
      ST_UPG_REQ   = 4'd7,
      ST_UPG_WAIT  = 4'd8,
      ST_UPG_UPD   = 4'd9,
      ST_RESPOND   = 4'd10,
      ST_ABORT     = 4'd11
   } cc_state_t;

   localparam int CC_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/cc_wait_timer.sv
// Wait-state timeout timer. Down-counter reloaded with TIMEOUT_CYCLES-1
// while clear is high; expire flags the enabled cycle where it hits zero,
// i.e. the TIMEOUT_CYCLES-th consecutive enabled cycle. TIMEOUT_CYCLES=0
// never expires.
module cc_wait_timer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [W-1:0] LOAD = (TIMEOUT_CYCLES > 0) ? W'(TIMEOUT_CYCLES - 1) : '0;

   logic [W-1:0] cnt;

   // reload on clear, count down while enabled, park at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= LOAD;
      end else if (clear) begin
         cnt <= LOAD;
      end else if (enable && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = (TIMEOUT_CYCLES != 0) && enable && (cnt == '0);

endmodule

// File: rtl/cache_controller.sv
// CPU-side cache control FSM sitting in front of the ACE controller.
// One CPU request at a time; issues ReadShared / MakeUnique / WriteClean
// pulses, waits for ace_ready, drives the tag/data/state array writes.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | ready for a CPU request
// LOOKUP    | evaluate hit / line state, count hit or miss
// WB_REQ    | issue WriteClean for the dirty victim (held during snoop)
// WB_WAIT   | wait for write-back completion
// FILL_REQ  | issue ReadShared (held during snoop)
// FILL_WAIT | wait for refill completion
// FILL_UPD  | write tag, refill data, line -> S
// UPG_REQ   | issue MakeUnique (held during snoop)
// UPG_WAIT  | wait for upgrade completion
// UPG_UPD   | write store data, line -> M
// RESPOND   | cpu_done
// ABORT     | cpu_done + cpu_err after a wait timeout
module cache_controller
   import cache_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = CC_TIMEOUT_DEF,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cpu_valid,
   input  logic             cpu_we,
   output logic             cpu_ready,
   output logic             cpu_done,
   output logic             cpu_err,
   input  logic             hit,
   input  logic [1:0]       line_state,
   input  logic             victim_dirty,
   input  logic             snoop_active,
   output logic             read_req,
   output logic             write_req,
   output logic             invalid_req,
   input  logic             ace_ready,
   output logic             tag_we,
   output logic             data_we,
   output logic             refill_sel,
   output logic             state_we,
   output logic [1:0]       state_next,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt,
   output logic             timeout_flag
);

   cc_state_t state_q, state_d;
   logic      we_q;
   logic      miss;
   logic      in_wait;
   logic      expire;
   logic      timeout_set;

   assign miss    = !hit || (line_state == LS_I);
   assign in_wait = (state_q == ST_WB_WAIT) || (state_q == ST_FILL_WAIT) ||
                    (state_q == ST_UPG_WAIT);

   cc_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (!in_wait),
      .enable(in_wait),
      .expire(expire)
   );

   // state register, latched request type, counters and sticky timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         hit_cnt      <= '0;
         miss_cnt     <= '0;
         timeout_flag <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_IDLE) && cpu_valid) begin
            we_q <= cpu_we;
         end
         if (state_q == ST_LOOKUP) begin
            if (miss) begin
               if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end else begin
               if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end
         end
         if (timeout_set) begin
            timeout_flag <= 1'b1;
         end
      end
   end

   // next-state and all combinational outputs
   always_comb begin
      state_d     = state_q;
      cpu_ready   = 1'b0;
      cpu_done    = 1'b0;
      cpu_err     = 1'b0;
      read_req    = 1'b0;
      write_req   = 1'b0;
      invalid_req = 1'b0;
      tag_we      = 1'b0;
      data_we     = 1'b0;
      refill_sel  = 1'b0;
      state_we    = 1'b0;
      state_next  = LS_I;
      timeout_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cpu_ready = 1'b1;
            if (cpu_valid) state_d = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            if (miss) begin
               state_d = victim_dirty ? ST_WB_REQ : ST_FILL_REQ;
            end else if (!we_q) begin
               state_d = ST_RESPOND;
            end else if (line_state == LS_S) begin
               state_d = ST_UPG_REQ;
            end else begin
               data_we    = 1'b1;
               state_we   = 1'b1;
               state_next = LS_M;
               state_d    = ST_RESPOND;
            end
         end
         ST_WB_REQ: begin
            if (!snoop_active) begin
               write_req = 1'b1;
               state_d   = ST_WB_WAIT;
            end
         end
         ST_FILL_REQ: begin
            if (!snoop_active) begin
               read_req = 1'b1;
               state_d  = ST_FILL_WAIT;
            end
         end
         ST_UPG_REQ: begin
            if (!snoop_active) begin
               invalid_req = 1'b1;
               state_d     = ST_UPG_WAIT;
            end
         end
         ST_WB_WAIT, ST_FILL_WAIT, ST_UPG_WAIT: begin
            // completion on the expiring cycle takes priority over the abort
            if (ace_ready) begin
               if (state_q == ST_WB_WAIT)        state_d = ST_FILL_REQ;
               else if (state_q == ST_FILL_WAIT) state_d = ST_FILL_UPD;
               else                              state_d = ST_UPG_UPD;
            end else if (expire) begin
               timeout_set = 1'b1;
               state_d     = ST_ABORT;
            end
         end
         ST_FILL_UPD: begin
            tag_we     = 1'b1;
            data_we    = 1'b1;
            refill_sel = 1'b1;
            state_we   = 1'b1;
            state_next = LS_S;
            state_d    = we_q ? ST_UPG_REQ : ST_RESPOND;
         end
         ST_UPG_UPD: begin
            data_we    = 1'b1;
            state_we   = 1'b1;
            state_next = LS_M;
            state_d    = ST_RESPOND;
         end
         ST_RESPOND: begin
            cpu_done = 1'b1;
            state_d  = ST_IDLE;
         end
         ST_ABORT: begin
            cpu_done = 1'b1;
            cpu_err  = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: each request pushes its expected
// completion record; the monitor pops and compares it on cpu_done.
module tb_cache_controller;
   import cache_pkg::*;

   localparam int TO = 8;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_valid, cpu_we, cpu_ready, cpu_done, cpu_err;
   logic          hit, victim_dirty, snoop_active;
   logic [1:0]    line_state;
   logic          read_req, write_req, invalid_req, ace_ready;
   logic          tag_we, data_we, refill_sel, state_we;
   logic [1:0]    state_next;
   logic [CW-1:0] hit_cnt, miss_cnt;
   logic          timeout_flag;

   always #5 clk = ~clk;

   cache_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_ready(cpu_ready),
      .cpu_done(cpu_done), .cpu_err(cpu_err),
      .hit(hit), .line_state(line_state), .victim_dirty(victim_dirty),
      .snoop_active(snoop_active),
      .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
      .ace_ready(ace_ready),
      .tag_we(tag_we), .data_we(data_we), .refill_sel(refill_sel),
      .state_we(state_we), .state_next(state_next),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .timeout_flag(timeout_flag)
   );

   typedef struct {
      logic       err;
      int         lat;
      int         n_wr, n_rd, n_inv, n_tag, n_data, n_swe;
      logic [1:0] last_sn;
      logic       last_rs;
      int         rd_at;
   } exp_t;

   exp_t  sb_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    n_done   = 0;
   int    n_stray  = 0;
   string cur_test = "init";
   logic  ace_en;
   int    ace_delay;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s [%s]: got %0d expected %0d", tag, cur_test, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic err, input int lat, input int wr, input int rd,
                               input int inv, input int tg, input int dt, input int swe,
                               input logic [1:0] sn, input logic rs, input int rd_at);
      exp_t e;
      e.err = err; e.lat = lat; e.n_wr = wr; e.n_rd = rd; e.n_inv = inv;
      e.n_tag = tg; e.n_data = dt; e.n_swe = swe; e.last_sn = sn; e.last_rs = rs;
      e.rd_at = rd_at;
      return e;
   endfunction

   // monitor: per-transaction observation, pop/compare on cpu_done
   initial begin
      bit         active = 0;
      int         cyc = 0;
      int         o_wr = 0, o_rd = 0, o_inv = 0, o_tag = 0, o_data = 0, o_swe = 0, o_rd_at = -1;
      logic [1:0] o_sn = 2'b00;
      logic       o_rs = 1'b0;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active = 0;
            sb_q.delete();
            continue;
         end
         if (active) begin
            cyc++;
            if (write_req)   o_wr++;
            if (invalid_req) o_inv++;
            if (read_req) begin
               o_rd++;
               if (o_rd_at < 0) o_rd_at = cyc;
            end
            if (tag_we) o_tag++;
            if (data_we) begin o_data++; o_rs = refill_sel; end
            if (state_we) begin o_swe++; o_sn = state_next; end
            if (cpu_done) begin
               if (sb_q.size() == 0) begin
                  chk("sb_unexpected_done", 1, 0);
               end else begin
                  e = sb_q.pop_front();
                  chk("latency",     cyc,     e.lat);
                  chk("cpu_err",     cpu_err, e.err);
                  chk("write_req_n", o_wr,    e.n_wr);
                  chk("read_req_n",  o_rd,    e.n_rd);
                  chk("inv_req_n",   o_inv,   e.n_inv);
                  chk("tag_we_n",    o_tag,   e.n_tag);
                  chk("data_we_n",   o_data,  e.n_data);
                  chk("state_we_n",  o_swe,   e.n_swe);
                  chk("state_next",  o_sn,    e.last_sn);
                  chk("refill_sel",  o_rs,    e.last_rs);
                  if (e.rd_at >= 0) chk("read_req_cycle", o_rd_at, e.rd_at);
               end
               active = 0;
               n_done++;
            end
         end else begin
            if (read_req || write_req || invalid_req || cpu_done || cpu_err) n_stray++;
            if (cpu_valid && cpu_ready) begin
               active = 1; cyc = 0;
               o_wr = 0; o_rd = 0; o_inv = 0; o_tag = 0; o_data = 0; o_swe = 0;
               o_rd_at = -1; o_sn = 2'b00; o_rs = 1'b0;
            end
         end
      end
   end

   // ACE responder: one-cycle ace_ready ace_delay cycles after each request pulse
   initial begin
      int ace_cnt = 0;
      ace_ready = 1'b0;
      forever begin
         @(negedge clk);
         ace_ready = 1'b0;
         if (!rst_n) begin
            ace_cnt = 0;
         end else begin
            if (ace_cnt > 0) begin
               ace_cnt--;
               if (ace_cnt == 0) ace_ready = 1'b1;
            end
            if (ace_en && (read_req || write_req || invalid_req)) ace_cnt = ace_delay;
         end
      end
   end

   task automatic apply_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; cpu_valid = 1'b0; snoop_active = 1'b0;
      #2;
      chk("rst_cpu_ready", cpu_ready, 1);
      chk("rst_outputs", {cpu_done, cpu_err, read_req, write_req, invalid_req,
                          tag_we, data_we, refill_sel, state_we, state_next}, 0);
      chk("rst_hit_cnt", hit_cnt, 0);
      chk("rst_miss_cnt", miss_cnt, 0);
      chk("rst_timeout_flag", timeout_flag, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic issue(input logic we, input logic h, input logic [1:0] ls,
                        input logic vd, input exp_t e);
      @(posedge clk); #1;
      cpu_valid = 1'b1; cpu_we = we; hit = h; line_state = ls; victim_dirty = vd;
      sb_q.push_back(e);
      @(posedge clk); #1;
      cpu_valid = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int start = n_done;
      int k = 0;
      while ((n_done == start) && (k < max)) begin
         @(negedge clk); #1;
         k++;
      end
      chk("done_within_bound", (n_done != start), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog [%s]: simulation did not finish", cur_test);
      $fatal(1, "watchdog");
   end

   initial begin
      int stray0;
      rst_n = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0; hit = 1'b0;
      line_state = LS_I; victim_dirty = 1'b0; snoop_active = 1'b0;
      ace_en = 1'b1; ace_delay = 5;

      cur_test = "reset";
      apply_reset();

      cur_test = "load_hit_E";
      issue(1'b0, 1'b1, LS_E, 1'b0, mk(0, 2, 0, 0, 0, 0, 0, 0, LS_I, 0, -1));
      wait_done(50);
      chk("hit_cnt", hit_cnt, 1);
      chk("miss_cnt", miss_cnt, 0);

      cur_test = "store_hit_S";
      issue(1'b1, 1'b1, LS_S, 1'b0, mk(0, 9, 0, 0, 1, 0, 1, 1, LS_M, 0, -1));
      wait_done(50);
      chk("hit_cnt", hit_cnt, 2);

      cur_test = "store_hit_E";
      issue(1'b1, 1'b1, LS_E, 1'b0, mk(0, 2, 0, 0, 0, 0, 1, 1, LS_M, 0, -1));
      wait_done(50);
      chk("hit_cnt", hit_cnt, 3);

      cur_test = "store_hit_M";
      issue(1'b1, 1'b1, LS_M, 1'b0, mk(0, 2, 0, 0, 0, 0, 1, 1, LS_M, 0, -1));
      wait_done(50);
      chk("hit_cnt_sat", hit_cnt, 3);

      apply_reset();
      cur_test = "load_miss_dirty";
      issue(1'b0, 1'b0, LS_M, 1'b1, mk(0, 15, 1, 1, 0, 1, 1, 1, LS_S, 1, 8));
      wait_done(80);
      chk("miss_cnt", miss_cnt, 1);
      chk("hit_cnt", hit_cnt, 0);

      cur_test = "store_miss_clean";
      issue(1'b1, 1'b0, LS_E, 1'b0, mk(0, 16, 0, 1, 1, 1, 2, 2, LS_M, 0, 2));
      wait_done(80);
      chk("miss_cnt", miss_cnt, 2);

      cur_test = "load_hit_on_I";
      issue(1'b0, 1'b1, LS_I, 1'b0, mk(0, 9, 0, 1, 0, 1, 1, 1, LS_S, 1, 2));
      wait_done(80);
      chk("miss_cnt", miss_cnt, 3);

      cur_test = "ace_on_timeout_cycle";
      ace_delay = TO;
      issue(1'b0, 1'b0, LS_S, 1'b0, mk(0, 12, 0, 1, 0, 1, 1, 1, LS_S, 1, 2));
      wait_done(80);
      chk("timeout_flag", timeout_flag, 0);
      chk("miss_cnt_sat", miss_cnt, 3);

      cur_test = "snoop_hold";
      ace_delay = 5;
      snoop_active = 1'b1;
      issue(1'b0, 1'b0, LS_S, 1'b0, mk(0, 19, 0, 1, 0, 1, 1, 1, LS_S, 1, 12));
      repeat (11) @(posedge clk);
      #1 snoop_active = 1'b0;
      wait_done(80);

      cur_test = "timeout";
      ace_en = 1'b0;
      issue(1'b0, 1'b0, LS_S, 1'b0, mk(1, 11, 0, 1, 0, 0, 0, 0, LS_I, 0, 2));
      wait_done(80);
      chk("timeout_flag", timeout_flag, 1);
      ace_en = 1'b1;

      cur_test = "after_timeout";
      issue(1'b0, 1'b1, LS_E, 1'b0, mk(0, 2, 0, 0, 0, 0, 0, 0, LS_I, 0, -1));
      wait_done(50);
      chk("timeout_flag_sticky", timeout_flag, 1);

      apply_reset();
      cur_test = "hit_saturation";
      for (int i = 0; i < 5; i++) begin
         issue(1'b0, 1'b1, LS_S, 1'b0, mk(0, 2, 0, 0, 0, 0, 0, 0, LS_I, 0, -1));
         wait_done(50);
         if (i == 1) chk("hit_cnt_2", hit_cnt, 2);
      end
      chk("hit_cnt_sat", hit_cnt, 3);

      cur_test = "reset_in_fill_wait";
      ace_en = 1'b0;
      issue(1'b0, 1'b0, LS_S, 1'b0, mk(0, 0, 0, 1, 0, 0, 0, 0, LS_I, 0, 2));
      repeat (4) @(posedge clk);
      apply_reset();
      chk("sb_flushed", sb_q.size(), 0);
      ace_en = 1'b1;
      stray0 = n_stray;
      repeat (10) @(posedge clk);
      #1;
      chk("no_reissue", n_stray - stray0, 0);
      chk("idle_ready", cpu_ready, 1);
      issue(1'b0, 1'b1, LS_E, 1'b0, mk(0, 2, 0, 0, 0, 0, 0, 0, LS_I, 0, -1));
      wait_done(50);
      chk("hit_cnt", hit_cnt, 1);

      cur_test = "end";
      chk("stray_pulses", n_stray, 0);
      chk("sb_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
